// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter
//   Round-robin arbiter that funnels four write requesters onto one registered
//   memory write bus, plus a bank zero-fill engine that sweeps every address of
//   one bank.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is combinational)
//   req_addr_N/data_N/bank_N requester write payload, N = 0..3
//   clear_start, clear_bank  start a zero-fill of clear_bank (IDLE only)
//   memory_addr/data         registered write address / data
//   select_memory            registered bank select
//   memory_we                registered write strobe, one cycle per write
//   grant_id                 requester whose write is on the bus (0 during clear)
//   busy                     high while a clear is running
//   clear_done               pulses with the final clear write
module mem_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [ADDR_W-1:0] req_addr_3,
  input  logic [DATA_W-1:0] req_data_0,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic [DATA_W-1:0] req_data_3,
  input  logic [1:0]        req_bank_0,
  input  logic [1:0]        req_bank_1,
  input  logic [1:0]        req_bank_2,
  input  logic [1:0]        req_bank_3,
  input  logic              clear_start,
  input  logic [1:0]        clear_bank,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [DATA_W-1:0] memory_data,
  output logic [1:0]        select_memory,
  output logic              memory_we,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              clear_done
);

  localparam int GID_W = 2;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Requester payloads gathered into packed arrays so the grant index can select them.
  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [N_REQ-1:0][DATA_W-1:0] data_v;
  logic [N_REQ-1:0][1:0]        bank_v;

  assign addr_v = {req_addr_3, req_addr_2, req_addr_1, req_addr_0};
  assign data_v = {req_data_3, req_data_2, req_data_1, req_data_0};
  assign bank_v = {req_bank_3, req_bank_2, req_bank_1, req_bank_0};

  logic [0:0]        state_q, state_d;
  logic [GID_W-1:0]  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] memory_addr_q, memory_addr_d;
  logic [DATA_W-1:0] memory_data_q, memory_data_d;
  logic [1:0]        select_memory_q, select_memory_d;
  logic              memory_we_q, memory_we_d;
  logic [GID_W-1:0]  grant_id_q, grant_id_d;
  logic              clear_done_q, clear_done_d;

  // Round-robin search starting just after the last granted requester.
  logic             gnt_found;
  logic [GID_W-1:0] gnt_idx;
  logic [GID_W-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_grant_q + k[GID_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A pending clear_start blocks arbitration so its cycle carries no transfer.
  logic arb_en;
  logic transfer;
  assign arb_en   = (state_q == S_IDLE) && !clear_start && !rst;
  assign transfer = arb_en && gnt_found;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[gnt_idx] = 1'b1;
  end

  logic [ADDR_W-1:0] addr_inc;
  assign addr_inc = memory_addr_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    memory_addr_d   = memory_addr_q;
    memory_data_d   = memory_data_q;
    select_memory_d = select_memory_q;
    grant_id_d      = grant_id_q;
    memory_we_d     = 1'b0;
    clear_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          // First clear write (address 0) goes out with the state change;
          // select_memory holds the latched bank for the whole sweep.
          state_d         = S_CLEAR;
          memory_addr_d   = '0;
          memory_data_d   = '0;
          select_memory_d = clear_bank;
          grant_id_d      = '0;
          memory_we_d     = 1'b1;
        end else if (transfer) begin
          memory_addr_d   = addr_v[gnt_idx];
          memory_data_d   = data_v[gnt_idx];
          select_memory_d = bank_v[gnt_idx];
          grant_id_d      = gnt_idx;
          last_grant_d    = gnt_idx;
          memory_we_d     = 1'b1;
        end
      end
      S_CLEAR: begin
        // The bus address doubles as the sweep counter; the last address ends
        // the clear, so the counter never wraps.
        if (memory_addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          memory_addr_d = addr_inc;
          memory_we_d   = 1'b1;
          clear_done_d  = (addr_inc == LAST_ADDR);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_q    <= GID_W'(N_REQ - 1);
      memory_addr_q   <= '0;
      memory_data_q   <= '0;
      select_memory_q <= '0;
      memory_we_q     <= 1'b0;
      grant_id_q      <= '0;
      clear_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      memory_addr_q   <= memory_addr_d;
      memory_data_q   <= memory_data_d;
      select_memory_q <= select_memory_d;
      memory_we_q     <= memory_we_d;
      grant_id_q      <= grant_id_d;
      clear_done_q    <= clear_done_d;
    end
  end

  assign memory_addr   = memory_addr_q;
  assign memory_data   = memory_data_q;
  assign select_memory = select_memory_q;
  assign memory_we     = memory_we_q;
  assign grant_id      = grant_id_q;
  assign clear_done    = clear_done_q;
  assign busy          = (state_q == S_CLEAR);

endmodule

// File: doc/mem_write_arbiter.md
MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of write requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the memory word-address width (1024 words per bank).
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning the memory data width.
REQ-004 The block SHALL have the following ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester write request.
- req_ready  output  4  per-requester accept; a transfer occurs when valid and ready are both high on a clk edge.
- req_addr_0..3  input  10 each  requester word address.
- req_data_0..3  input  8 each  requester write data.
- req_bank_0..3  input  2 each  requester target bank (0-3).
- clear_start  input  1  request to zero-fill one bank.
- clear_bank  input  2  bank to clear, sampled with clear_start.
- memory_addr  output  10  registered address to the memory banks.
- memory_data  output  8  registered write data.
- select_memory  output  2  registered bank select.
- memory_we  output  1  registered write strobe, one cycle per write.
- grant_id  output  2  registered index of the requester whose write is on the bus.
- busy  output  1  high while in state CLEAR.
- clear_done  output  1  one-cycle pulse when a clear completes.

Function
REQ-005 The block SHALL implement two states: IDLE (arbitrate requesters) and CLEAR (zero-fill a bank).
REQ-006 In IDLE, when any req_valid bit is high and clear_start is low, the block SHALL assert exactly one req_ready bit, combinationally, chosen round-robin.
REQ-007 The round-robin search SHALL start at index (last_grant+1) mod 4 and select the first requester with valid high; last_grant SHALL update to the granted index on each transfer.
REQ-008 req_ready SHALL be 0 for all requesters whose valid is low, in CLEAR, and while clear_start is high in IDLE.
REQ-009 On a transfer from requester i, the block SHALL drive memory_addr=req_addr_i, memory_data=req_data_i, select_memory=req_bank_i, grant_id=i and memory_we=1 on the next cycle (latency 1).
REQ-010 In any cycle with no transfer and not in CLEAR, memory_we SHALL be 0 and the other bus outputs SHALL hold their previous values.
REQ-011 A requester holding valid high continuously SHALL be granted at most once per 4 consecutive grants while all 4 requesters are valid.
REQ-012 clear_start high in IDLE SHALL take priority over all requests, latch clear_bank, and move to CLEAR on the next edge; no transfer SHALL occur in that cycle.
REQ-013 In CLEAR, the block SHALL issue writes on consecutive cycles to addresses 0 through 1023 of the latched bank with memory_data=0, memory_we=1, grant_id=0: 1024 writes, the first one cycle after clear_start is accepted.
REQ-014 The block SHALL pulse clear_done for one cycle coincident with the write to address 1023 and return to IDLE on the following edge; memory_we SHALL be 0 in the first IDLE cycle unless a transfer was accepted.
REQ-015 clear_start asserted while in CLEAR SHALL be ignored and SHALL NOT be queued.
REQ-016 busy SHALL be high in every CLEAR cycle and low otherwise.
REQ-017 The address counter in CLEAR SHALL NOT wrap: reaching address 1023 SHALL always terminate the clear.

Reset
REQ-018 On rst high at a clk edge, the block SHALL enter IDLE and set memory_addr=0, memory_data=0, select_memory=0, memory_we=0, grant_id=0, busy=0, clear_done=0 and last_grant=3, so that requester 0 has highest priority first.
REQ-019 req_ready SHALL be 0 during any cycle in which rst is high.
REQ-020 Reset during CLEAR SHALL abort the clear immediately, with no clear_done pulse and no further writes.

Verification
REQ-021 The bench SHALL cover a single request: requester 0 valid with addr=2, data=30, bank=0 -> ready0 high the same cycle; next cycle memory_we=1, memory_addr=2, memory_data=30, select_memory=0, grant_id=0.
REQ-022 The bench SHALL cover full contention: all 4 valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, with one memory_we per cycle.
REQ-023 The bench SHALL cover a bank clear: clear_start=1 with clear_bank=3 -> busy for 1024 cycles; writes to bank 3, addresses 0..1023, data 0; clear_done pulses with address 1023; requests stalled meanwhile.
REQ-024 The bench SHALL cover simultaneous events: clear_start and req_valid=4'b0010 in the same cycle -> no ready; clear runs; requester 1 is granted in the first IDLE cycle after the clear.
REQ-025 The bench SHALL cover reset mid-clear: rst at clear address 500 -> next cycle memory_we=0, busy=0, no clear_done, all outputs at reset values.
REQ-026 The bench SHALL cover ignored restart: clear_start pulsed during CLEAR -> exactly one clear_done and a return to IDLE.
